// File: rtl/aes_pkg.sv
// Shared AES-128 constants, controller state encoding and GF(2^8) doubling helper.
package aes_pkg;
    localparam int AES_NR = 10;
    localparam int AES_KW = 128;
    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_EXPAND = ST_EXPAND,
        S_DONE   = ST_DONE
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction
endpackage

// File: rtl/aes_key_round.sv
// Combinational AES-128 key-expansion step: next four words from the previous four and Rcon.
module aes_key_round (
    input  logic [127:0] prev_key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);
    logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
    logic [31:0] rot, sub, t;

    assign w0  = prev_key[127:96];
    assign w1  = prev_key[95:64];
    assign w2  = prev_key[63:32];
    assign w3  = prev_key[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        Sbox u_sbox (
            .byte_val (rot[8*g +: 8]),
            .sub_val  (sub[8*g +: 8])
        );
    end

    assign t  = sub ^ {rcon, 24'h0};
    assign w4 = w0 ^ t;
    assign w5 = w1 ^ w4;
    assign w6 = w2 ^ w5;
    assign w7 = w3 ^ w6;
    assign next_key = {w4, w5, w6, w7};
endmodule

// File: rtl/sbox.sv
// AES forward S-box as a constant lookup; row-major FIPS-197 table, byte 0x00 in the top bits.
module Sbox (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // ~byte_val == 255 - byte_val, so this picks entry byte_val counted from the MSB end.
    assign sub_val = SBOX_TBL[{~byte_val, 3'b000} +: 8];
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule: one shared round unit, 11-entry key store, parallel and indexed read-out.
//   state    | meaning
//   S_IDLE   | no valid schedule, waiting for a key
//   S_EXPAND | writing rk[round] each cycle, rounds 1..10
//   S_DONE   | all round keys valid, a new key may be accepted
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = AES_KW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KW-1:0]         key_in,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic                  abort,
    input  logic [3:0]            rd_idx,
    output logic [KW-1:0]         rd_data,
    output logic [(NR+1)*KW-1:0]  rk_all,
    output logic                  busy,
    output logic                  keys_ready
);
    localparam logic [3:0] LAST_IDX = 4'(NR);

    state_t      state;
    logic [3:0]  round;
    logic [7:0]  rcon;
    logic [KW-1:0] prev_key;
    logic [KW-1:0] next_key;
    logic [KW-1:0] rk [0:NR];
    logic        accept;

    assign accept = key_valid & key_ready;

    aes_key_round u_round (
        .prev_key (prev_key),
        .rcon     (rcon),
        .next_key (next_key)
    );

    for (genvar i = 0; i <= NR; i++) begin : g_rk_all
        assign rk_all[KW*i +: KW] = rk[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            round      <= 4'd0;
            rcon       <= RCON_INIT;
            prev_key   <= '0;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
            rd_data    <= '0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else begin
            // Non-blocking read: a same-edge write to rd_idx is seen next cycle.
            rd_data <= (rd_idx <= LAST_IDX) ? rk[rd_idx] : '0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        rk[0]      <= key_in;
                        prev_key   <= key_in;
                        round      <= 4'd1;
                        rcon       <= RCON_INIT;
                        keys_ready <= 1'b0;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        key_ready <= 1'b1;
                    end else begin
                        for (int i = 1; i <= NR; i++)
                            if (round == 4'(i)) rk[i] <= next_key;
                        prev_key <= next_key;
                        rcon     <= xtime(rcon);
                        round    <= round + 4'd1;
                        if (round == LAST_IDX) begin
                            state      <= S_DONE;
                            keys_ready <= 1'b1;
                            busy       <= 1'b0;
                            key_ready  <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl; reference schedule built from a GF(2^8)-derived S-box.
module tb_aes_key_sched_ctrl;
    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  key_in;
    logic          key_valid;
    logic          key_ready;
    logic          abort;
    logic [3:0]    rd_idx;
    logic [127:0]  rd_data;
    logic [1407:0] rk_all;
    logic          busy;
    logic          keys_ready;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .abort      (abort),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .rk_all     (rk_all),
        .busy       (busy),
        .keys_ready (keys_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    sbox_m [256];
    logic [7:0]    rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    logic [1407:0] key_q [$];
    logic [127:0]  rd_q  [$];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in, b = b_in, p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1B) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [1407:0] r;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]}
                    ^ {rcon_tbl[i/4-1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 11; j++)
            r[128*j +: 128] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic accept_key(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        key_q.push_back(expand(k));
        step();
        key_valid = 1'b0;
        check("accept_busy", 128'(busy), 128'(1'b1));
        check("accept_key_ready", 128'(key_ready), 128'(1'b0));
        check("accept_rk0", rk_all[127:0], k);
    endtask

    // Bounded wait for keys_ready; verifies each round key as it lands, then the whole store.
    task automatic wait_done(output logic [1407:0] got_model);
        logic [1407:0] exp = key_q[0];
        int n = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k <= 10) check("rk_step", rk_all[128*k +: 128], exp[128*k +: 128]);
            if (keys_ready) begin
                n = k;
                break;
            end
        end
        check("ready_latency", 128'(n), 128'(10));
        exp = key_q.pop_front();
        for (int i = 0; i < 11; i++) check("rk_all", rk_all[128*i +: 128], exp[128*i +: 128]);
        got_model = exp;
    endtask

    task automatic read_all(input logic [1407:0] model);
        for (int idx = 0; idx < 16; idx++) begin
            rd_idx = 4'(idx);
            rd_q.push_back(idx <= 10 ? model[128*idx +: 128] : 128'h0);
            step();
            check("rd_data", rd_data, rd_q.pop_front());
        end
    endtask

    initial begin
        logic [1407:0] model;
        logic [127:0]  rk_key, key_a, key_b;
        logic [31:0]   w0n, w0p, w3p;
        logic [7:0]    rc;
        bit            seen;
        int            ra, acc, rb;

        rst = 1'b1; key_valid = 1'b0; abort = 1'b0; rd_idx = 4'd0; key_in = '0;
        build_sbox();
        repeat (3) step();
        check("rst_key_ready", 128'(key_ready), 128'(1'b1));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_keys_ready", 128'(keys_ready), 128'(1'b0));
        check("rst_rd_data", rd_data, 128'h0);
        for (int i = 0; i < 11; i++) check("rst_rk_all", rk_all[128*i +: 128], 128'h0);
        rst = 1'b0;
        step();

        // FIPS-197 vector
        accept_key(FIPS_KEY);
        wait_done(model);
        check("fips_rk1", rk_all[255:128], FIPS_RK1);
        check("fips_rk10", rk_all[1407:1280], FIPS_RK10);
        for (int i = 1; i <= 10; i++) begin
            w0n = rk_all[128*i + 96 +: 32];
            w0p = rk_all[128*(i-1) + 96 +: 32];
            w3p = rk_all[128*(i-1) +: 32];
            rc  = w0n[31:24] ^ w0p[31:24] ^ sbox_m[w3p[23:16]];
            check("rcon", 128'(rc), 128'(rcon_tbl[i-1]));
        end
        read_all(model);

        // All-zero key and out-of-range read
        accept_key(128'h0);
        wait_done(model);
        check("zero_rk1", rk_all[255:128], ZERO_RK1);
        rd_idx = 4'd12;
        step();
        check("rd_idx12", rd_data, 128'h0);

        // Abort sampled at edge T+4
        rk_key = {$urandom, $urandom, $urandom, $urandom};
        accept_key(rk_key);
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        key_q.delete();
        check("abort_busy", 128'(busy), 128'(1'b0));
        check("abort_key_ready", 128'(key_ready), 128'(1'b1));
        check("abort_keys_ready", 128'(keys_ready), 128'(1'b0));
        seen = 1'b0;
        repeat (12) begin
            step();
            if (keys_ready) seen = 1'b1;
        end
        check("abort_no_ready", 128'(seen), 128'(1'b0));
        accept_key(FIPS_KEY);
        wait_done(model);
        check("post_abort_rk10", rk_all[1407:1280], FIPS_RK10);

        // Reset mid-expansion
        rk_key = {$urandom, $urandom, $urandom, $urandom};
        accept_key(rk_key);
        repeat (5) step();
        rst = 1'b1;
        #1;
        key_q.delete();
        check("midrst_key_ready", 128'(key_ready), 128'(1'b1));
        check("midrst_busy", 128'(busy), 128'(1'b0));
        check("midrst_keys_ready", 128'(keys_ready), 128'(1'b0));
        check("midrst_rd_data", rd_data, 128'h0);
        check("midrst_rk_all", 128'(|rk_all), 128'(1'b0));
        step();
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            step();
            if (keys_ready) seen = 1'b1;
        end
        check("midrst_no_ready", 128'(seen), 128'(1'b0));

        // Back-to-back keys with key_valid held
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = {$urandom, $urandom, $urandom, $urandom};
        key_in = key_a; key_valid = 1'b1;
        key_q.push_back(expand(key_a));
        step();
        key_in = key_b;
        ra = -1; acc = -1; rb = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (ra < 0 && keys_ready) begin
                ra = k;
                model = key_q.pop_front();
                check("b2b_a_rk10", rk_all[1407:1280], model[1407:1280]);
            end else if (ra >= 0 && acc < 0 && busy) begin
                acc = k;
                key_valid = 1'b0;
                key_q.push_back(expand(key_b));
                check("b2b_drop", 128'(keys_ready), 128'(1'b0));
            end else if (acc >= 0 && keys_ready) begin
                rb = k;
                model = key_q.pop_front();
                check("b2b_b_rk10", rk_all[1407:1280], model[1407:1280]);
                break;
            end
        end
        key_valid = 1'b0;
        check("b2b_first_ready", 128'(ra), 128'(10));
        check("b2b_second_accept", 128'(acc), 128'(11));
        check("b2b_second_ready", 128'(rb), 128'(21));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
